// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle ripple adder that adds CHUNK bits of the operands
// per clock. IDLE captures the operands, ADD walks the chunks from LSB to MSB,
// and DONE produces the result-valid pulse.
// Optional feature: define CHUNK_ADDER_SUB_EN to add the in_sub port, which
// selects A + ~B + ~in_carry (subtract with borrow) instead of A + B + in_carry.
module chunk_adder #(
  parameter int BITS  = 16,
  parameter int CHUNK = 4
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  input  logic            in_start,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  input  logic            in_carry,
`ifdef CHUNK_ADDER_SUB_EN
  input  logic            in_sub,
`endif
  output logic [BITS-1:0] out_sum,
  output logic            out_carry,
  output logic            out_overflow,
  output logic            out_busy,
  output logic            out_ready
);

  localparam int N    = BITS / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [BITS-1:0]   a_q, a_d;
  logic [BITS-1:0]   b_q, b_d;     // holds ~B when subtracting
  logic              c_q, c_d;     // running carry between chunks
  logic [BITS-1:0]   sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              ready_q, ready_d;

  logic [31:0]       base;
  logic [CHUNK-1:0]  a_ch, b_ch;
  logic [CHUNK:0]    csum;

  // Current chunk slice and its CHUNK+1 bit sum including the running carry
  always_comb begin
    base = 32'(idx_q) * 32'(CHUNK);
    a_ch = a_q[base +: CHUNK];
    b_ch = b_q[base +: CHUNK];
    csum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_q};
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_start) begin
          a_d = in_a;
`ifdef CHUNK_ADDER_SUB_EN
          // Subtraction folds into the adder by inverting B and the carry-in
          b_d = in_sub ? ~in_b : in_b;
          c_d = in_sub ? ~in_carry : in_carry;
`else
          b_d = in_b;
          c_d = in_carry;
`endif
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[base +: CHUNK] = csum[CHUNK-1:0];
        c_d   = csum[CHUNK];
        idx_d = idx_q + 1'b1;
        if (idx_q == IDXW'(N-1)) begin
          state_d = DONE;
          carry_d = csum[CHUNK];
          // carry into the MSB is a^b^s at that bit; overflow = cin ^ cout
          ovf_d   = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ csum[CHUNK-1] ^ csum[CHUNK];
        end
      end
      DONE: begin
        // ready is registered, so the pulse lands one edge after DONE
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
    end
  end

  assign out_sum      = sum_q;
  assign out_carry    = carry_q;
  assign out_overflow = ovf_q;
  assign out_busy     = (state_q != IDLE);
  assign out_ready    = ready_q;

endmodule

// File: tb/tb_chunk_adder.sv
// tb_chunk_adder: directed checks of chunk_adder for BITS=16/CHUNK=4 and
// BITS=8/CHUNK=8 instances sharing one clock and reset.
module tb_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic [15:0] sum;
  logic        cout, ovf, busy, ready;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic [7:0]  sum8;
  logic        cout8, ovf8, busy8, ready8;

`ifdef CHUNK_ADDER_SUB_EN
  logic        sub = 1'b0;
  logic        sub8 = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chunk_adder #(.BITS(16), .CHUNK(4)) u_dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start),
    .in_a(a), .in_b(b), .in_carry(cin),
`ifdef CHUNK_ADDER_SUB_EN
    .in_sub(sub),
`endif
    .out_sum(sum), .out_carry(cout), .out_overflow(ovf),
    .out_busy(busy), .out_ready(ready)
  );

  chunk_adder #(.BITS(8), .CHUNK(8)) u_dut8 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start8),
    .in_a(a8), .in_b(b8), .in_carry(cin8),
`ifdef CHUNK_ADDER_SUB_EN
    .in_sub(sub8),
`endif
    .out_sum(sum8), .out_carry(cout8), .out_overflow(ovf8),
    .out_busy(busy8), .out_ready(ready8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one 16-bit addition; returns with the accept edge just passed
  task automatic go16(input logic [15:0] ia, input logic [15:0] ib, input logic ic);
    a = ia; b = ib; cin = ic; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges from the accept edge until ready is seen (0 = never within budget)
  task automatic wait16(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ready) begin lat = i; break; end
    end
  endtask

  task automatic run16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    go16(ia, ib, ic);
    wait16(lat);
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_carry"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    tick();
    chk({tag, "_ready_1cyc"}, ready, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat, pulses;
    logic [15:0] seen;

    // asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sum", sum, 0);
    chk("rst_carry", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_sum8", sum8, 0);
    #10 rst_n = 1'b1;        // t=12, next rising edge at 15 accepts start

    // first start after release, basic sum
    a = 16'h1234; b = 16'h2345; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("basic_busy", busy, 1);
    wait16(lat);
    chk("basic_lat", lat, 5);
    chk("basic_sum", sum, 16'h3579);
    chk("basic_carry", cout, 0);
    chk("basic_ovf", ovf, 0);
    tick();
    chk("basic_ready_1cyc", ready, 0);

    run16("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run16("ovfpos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run16("ovfneg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // reset in the 3rd ADD cycle: outputs clear without a clock edge
    go16(16'hABCD, 16'h1111, 1'b0);
    tick();
    tick();
    chk("abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sum", sum, 0);
    chk("abort_carry", cout, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_busy0", busy, 0);
    chk("abort_ready", ready, 0);
    tick(); tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ready) pulses++;
    end
    chk("abort_no_ready", pulses, 0);
    run16("post_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    run16("cin", 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0);

    // start re-pulsed while busy with new operands is ignored
    go16(16'h1111, 16'h2222, 1'b0);
    tick();
    a = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0; seen = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ready) begin pulses++; seen = sum; end
    end
    chk("busy_ign_pulses", pulses, 1);
    chk("busy_ign_sum", seen, 16'h3333);

    // start held high: next addition starts right after the ready cycle
    go16(16'h0001, 16'h0001, 1'b0);
    start = 1'b1;
    a = 16'h0003;
    wait16(lat);
    chk("held_lat1", lat, 5);
    chk("held_sum1", sum, 16'h0002);
    wait16(lat);
    start = 1'b0;
    chk("held_lat2", lat, 6);
    chk("held_sum2", sum, 16'h0004);
    tick();

`ifdef CHUNK_ADDER_SUB_EN
    sub = 1'b1;
    run16("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run16("sub_plain",  16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
    sub = 1'b0;
    run16("sub_off",    16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0, 1'b0);
`endif

    // single-chunk instance: latency 2
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ready8) begin lat = i; break; end
    end
    chk("n1_lat", lat, 2);
    chk("n1_sum", sum8, 8'h00);
    chk("n1_carry", cout8, 1);
    chk("n1_ovf", ovf8, 1);
    tick();
    chk("n1_ready_1cyc", ready8, 0);

    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    chk("n1b_ready", ready8, 1);
    chk("n1b_sum", sum8, 8'h04);
    chk("n1b_carry", cout8, 0);
    chk("n1b_ovf", ovf8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/chunk_adder.md
CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001 Parameter BITS, default 16, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; BITS SHALL be an integer multiple of CHUNK, and the number of chunks is N = BITS/CHUNK.
REQ-003 in_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 in_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_start  input  1  request to start an addition; sampled only in IDLE.
REQ-006 in_a  input  BITS  operand A; captured on an accepted start.
REQ-007 in_b  input  BITS  operand B; captured on an accepted start.
REQ-008 in_carry  input  1  carry-in; captured on an accepted start.
REQ-009 out_sum  output  BITS  result register.
REQ-010 out_carry  output  1  carry-out of the most significant bit.
REQ-011 out_overflow  output  1  two's-complement overflow of the result.
REQ-012 out_busy  output  1  high in states ADD and DONE.
REQ-013 out_ready  output  1  one-cycle pulse when the result becomes valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-015 In IDLE with in_start=1, the block SHALL latch in_a, in_b and in_carry, clear the chunk index to 0, and go to ADD.
REQ-016 In ADD, each cycle SHALL add chunk k of A and B, plus the running carry, and write the result into bits [k*CHUNK +: CHUNK] of out_sum.
- The chunk carry-out SHALL become the running carry.
- k SHALL increment by 1.
- After chunk N-1, the FSM SHALL go to DONE.
REQ-017 In DONE, out_ready=1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-018 Latency: out_ready SHALL assert on the (N+1)th rising edge after the edge that accepted in_start; for BITS=16, CHUNK=4 this is 5 cycles.
REQ-019 out_carry SHALL equal the final running carry.
REQ-020 out_overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 out_sum, out_carry and out_overflow SHALL be stable and valid from out_ready until the next accepted start.
REQ-022 Bits of out_sum not yet written during ADD are unspecified.
REQ-023 in_start SHALL be ignored while out_busy=1, and changes to any operand input while busy SHALL have no effect.
REQ-024 in_start held high continuously SHALL start a new addition on the first IDLE cycle after each DONE.
REQ-025 The arithmetic is modulo 2^BITS; the only indications of wrap-around are the carry and overflow flags.
REQ-026 CHUNK=BITS (N=1) is legal and SHALL give a latency of 2 cycles.

Reset
REQ-027 in_rst_n=0 SHALL immediately, without waiting for a clock edge, set the following:
- state to IDLE;
- chunk index to 0;
- out_sum, out_carry, out_overflow, out_busy and out_ready to 0;
- all latched operands to 0.
REQ-028 Reset asserted during ADD or DONE SHALL abort the operation, and no out_ready pulse SHALL follow.
REQ-029 The first start after reset is released SHALL be accepted on the first rising edge at which in_rst_n=1.

Configuration
REQ-030 Macro CHUNK_ADDER_SUB_EN SHALL control subtraction support.
- When defined: an extra port in_sub (input, 1 bit) exists and is captured on start.
- With in_sub=1, the block SHALL compute A + ~B + ~in_carry, so out_carry=0 signals a borrow.
- With in_sub=0, the block behaves as the adder.
REQ-031 When CHUNK_ADDER_SUB_EN is not defined, in_sub SHALL not exist and the block SHALL only add.

Verification
REQ-032 BITS=16, CHUNK=4: A=0x1234, B=0x2345, carry=0, start -> out_ready exactly 5 cycles later; sum=0x3579, carry=0, overflow=0.
REQ-033 A=0xFFFF, B=0x0001 -> sum=0x0000, carry=1, overflow=0; then A=0x7FFF, B=0x0001 -> sum=0x8000, carry=0, overflow=1.
REQ-034 A=0x1111, B=0x2222, start; pulse start again 2 cycles later with A=0xFFFF -> second start ignored; sum=0x3333, and only one out_ready pulse.
REQ-035 Start an addition, then drive in_rst_n=0 in the 3rd ADD cycle -> all outputs become 0 immediately with no clock edge; no out_ready; the next start after release returns the correct result.
REQ-036 With CHUNK_ADDER_SUB_EN: in_sub=1, in_carry=0, A=0x0005, B=0x0007 -> sum=0xFFFE, carry=0 (borrow).
REQ-037 BITS=8, CHUNK=8: A=0x80, B=0x80 -> out_ready after 2 cycles; sum=0x00, carry=1, overflow=1.
